// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: bit-level SD CMD line engine.
// Serialises a command MSB-first onto the CMD pad. When a response is
// expected it turns the line around and waits for the start bit, then
// deserialises the reply. It reports a timeout if no start bit arrives,
// and holds the result until the controller acknowledges it.
module sd_cmd_phy #(
    parameter int CMD_BITS  = 48,
    parameter int RESP_BITS = 48,
    parameter int TIMEOUT   = 64
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 strobe_in,
    input  logic                 expect_resp,
    input  logic [CMD_BITS-1:0]  cmd_in,
    input  logic                 ack_in,
    input  logic                 pad_data_out,
    output logic                 pad_data_in,
    output logic                 pad_output_input,
    output logic                 pad_enable,
    output logic                 busy,
    output logic [RESP_BITS-1:0] response,
    output logic                 response_valid,
    output logic                 timeout
);

    localparam int TXC_W = $clog2(CMD_BITS + 1);
    localparam int RXC_W = $clog2(RESP_BITS + 1);
    localparam int TOC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CMD_BITS-1:0]  tx_q, tx_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 exp_q, exp_d;
    logic [TOC_W-1:0]     wait_cnt_q, wait_cnt_d;
    // Bits received so far; the final bit is appended straight into response.
    logic [RESP_BITS-2:0] rx_q, rx_d;
    logic [RXC_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic                 pad_data_in_q, pad_data_in_d;
    logic                 pad_oe_q, pad_oe_d;
    logic                 pad_en_q, pad_en_d;
    logic                 busy_q, busy_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    logic tx_last;
    logic rx_last;
    logic wait_expired;
    logic start_seen;

    assign tx_last      = (tx_cnt_q == TXC_W'(CMD_BITS - 1));
    assign rx_last      = (rx_cnt_q == RXC_W'(RESP_BITS - 1));
    assign wait_expired = (wait_cnt_q == TOC_W'(TIMEOUT - 1));
    assign start_seen   = ~pad_data_out;

    // State register; an active-low reset aborts any transfer back to IDLE.
    always_ff @(posedge sd_clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start bit takes priority over an expiring wait counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (strobe_in) state_d = S_SEND;
            S_SEND: if (tx_last)   state_d = exp_q ? S_WAIT : S_DONE;
            S_WAIT: begin
                if (start_seen)        state_d = S_RECV;
                else if (wait_expired) state_d = S_DONE;
            end
            S_RECV: if (rx_last)   state_d = S_DONE;
            S_DONE: if (ack_in)    state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values, derived from the current and next state.
    always_comb begin
        tx_d          = tx_q;
        tx_cnt_d      = tx_cnt_q;
        exp_d         = exp_q;
        wait_cnt_d    = wait_cnt_q;
        rx_d          = rx_q;
        rx_cnt_d      = rx_cnt_q;
        pad_data_in_d = 1'b1;
        response_d    = response_q;
        valid_d       = valid_q;
        timeout_d     = timeout_q;
        pad_en_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (strobe_in) begin
                    // Rotate-left shifter: the current bit always sits in the MSB.
                    tx_d          = cmd_in;
                    exp_d         = expect_resp;
                    tx_cnt_d      = '0;
                    pad_data_in_d = cmd_in[CMD_BITS-1];
                end
            end
            S_SEND: begin
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    wait_cnt_d = '0;
                end else begin
                    tx_d          = {tx_q[CMD_BITS-2:0], tx_q[CMD_BITS-1]};
                    tx_cnt_d      = tx_cnt_q + TXC_W'(1);
                    pad_data_in_d = tx_q[CMD_BITS-2];
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + TOC_W'(1);
                if (start_seen) begin
                    // The start bit is always 0, so the shifter is simply cleared.
                    rx_d     = '0;
                    rx_cnt_d = RXC_W'(1);
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                end
            end
            S_RECV: begin
                rx_d     = {rx_q[RESP_BITS-3:0], pad_data_out};
                rx_cnt_d = rx_cnt_q + RXC_W'(1);
                if (rx_last) begin
                    response_d = {rx_q, pad_data_out};
                    valid_d    = 1'b1;
                end
            end
            S_DONE: begin
                if (ack_in) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: ;
        endcase

        pad_oe_d = !((state_d == S_WAIT) || (state_d == S_RECV));
        busy_d   = (state_d != S_IDLE);
    end

    // Datapath and output registers with their reset values.
    always_ff @(posedge sd_clock) begin
        if (!reset) begin
            tx_q          <= '0;
            tx_cnt_q      <= '0;
            exp_q         <= 1'b0;
            wait_cnt_q    <= '0;
            rx_q          <= '0;
            rx_cnt_q      <= '0;
            pad_data_in_q <= 1'b1;
            pad_oe_q      <= 1'b1;
            pad_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            response_q    <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            tx_q          <= tx_d;
            tx_cnt_q      <= tx_cnt_d;
            exp_q         <= exp_d;
            wait_cnt_q    <= wait_cnt_d;
            rx_q          <= rx_d;
            rx_cnt_q      <= rx_cnt_d;
            pad_data_in_q <= pad_data_in_d;
            pad_oe_q      <= pad_oe_d;
            pad_en_q      <= pad_en_d;
            busy_q        <= busy_d;
            response_q    <= response_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign pad_data_in      = pad_data_in_q;
    assign pad_output_input = pad_oe_q;
    assign pad_enable       = pad_en_q;
    assign busy             = busy_q;
    assign response         = response_q;
    assign response_valid   = valid_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: directed and randomized command
// transactions checked against a transaction-level expectation model.
module tb_sd_cmd_phy;

    localparam int CB = 48;
    localparam int RB = 48;
    localparam int TO = 64;

    logic          sd_clock = 1'b0;
    logic          reset;
    logic          strobe_in;
    logic          expect_resp;
    logic [CB-1:0] cmd_in;
    logic          ack_in;
    logic          pad_data_out;
    logic          pad_data_in;
    logic          pad_output_input;
    logic          pad_enable;
    logic          busy;
    logic [RB-1:0] response;
    logic          response_valid;
    logic          timeout;

    int vectors    = 0;
    int miscompares = 0;

    // Model: last completed frame (0 after reset).
    logic [RB-1:0] model_resp;

    sd_cmd_phy #(.CMD_BITS(CB), .RESP_BITS(RB), .TIMEOUT(TO)) dut (
        .sd_clock        (sd_clock),
        .reset           (reset),
        .strobe_in       (strobe_in),
        .expect_resp     (expect_resp),
        .cmd_in          (cmd_in),
        .ack_in          (ack_in),
        .pad_data_out    (pad_data_out),
        .pad_data_in     (pad_data_in),
        .pad_output_input(pad_output_input),
        .pad_enable      (pad_enable),
        .busy            (busy),
        .response        (response),
        .response_valid  (response_valid),
        .timeout         (timeout)
    );

    always #5 sd_clock = ~sd_clock;

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic got, input logic expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, got, expv);
        end
    endtask

    task automatic chkw(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // One full command: d = edge (counted from WAIT entry) at which the start
    // bit is sampled; d > TO means the line stays high for the whole wait.
    task automatic run_txn(input logic [CB-1:0] cmd, input logic exp, input int d,
                           input logic [RB-1:0] resp_bits, input int hold);
        logic exp_valid;
        logic exp_to;
        exp_valid = exp && (d <= TO);
        exp_to    = exp && (d > TO);

        strobe_in   = 1'b1;
        cmd_in      = cmd;
        expect_resp = exp;
        tick();
        strobe_in   = 1'b0;
        cmd_in      = CB'({$urandom(), $urandom()});
        expect_resp = 1'($urandom());

        for (int k = 0; k < CB; k++) begin
            chk1("send_bit", pad_data_in, cmd[CB-1-k]);
            chk1("send_oe", pad_output_input, 1'b1);
            chk1("send_busy", busy, 1'b1);
            strobe_in = (k == 20);
            tick();
        end
        strobe_in = 1'b0;

        if (exp) begin
            chk1("wait_oe", pad_output_input, 1'b0);
            if (exp_to) begin
                for (int j = 1; j <= TO; j++) begin
                    pad_data_out = 1'b1;
                    tick();
                    if (j < TO) chk1("wait_no_early_timeout", timeout, 1'b0);
                end
            end else begin
                for (int j = 1; j <= d; j++) begin
                    pad_data_out = (j == d) ? 1'b0 : 1'b1;
                    tick();
                    chk1("wait_no_timeout", timeout, 1'b0);
                end
                for (int b = RB - 2; b >= 0; b--) begin
                    pad_data_out = resp_bits[b];
                    strobe_in    = (b == 30);
                    tick();
                    if (b > 0) begin
                        chk1("rx_valid_early", response_valid, 1'b0);
                        chk1("rx_oe", pad_output_input, 1'b0);
                    end
                end
                strobe_in    = 1'b0;
                pad_data_out = 1'($urandom());
                model_resp   = {1'b0, resp_bits[RB-2:0]};
            end
        end

        chk1("done_valid", response_valid, exp_valid);
        chk1("done_timeout", timeout, exp_to);
        chkw("done_response", response, model_resp);
        chk1("done_oe", pad_output_input, 1'b1);
        chk1("done_data", pad_data_in, 1'b1);

        for (int h = 0; h < hold; h++) begin
            strobe_in = 1'($urandom());
            tick();
            chk1("hold_busy", busy, 1'b1);
            chk1("hold_valid", response_valid, exp_valid);
        end

        ack_in    = 1'b1;
        strobe_in = 1'b1;
        tick();
        ack_in    = 1'b0;
        strobe_in = 1'b0;
        chk1("ack_busy", busy, 1'b0);
        chk1("ack_valid", response_valid, 1'b0);
        chk1("ack_timeout", timeout, 1'b0);
        chkw("ack_response_kept", response, model_resp);

        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk1("idle_ack_ignored", busy, 1'b0);
        chk1("idle_data", pad_data_in, 1'b1);
        pad_data_out = 1'b1;
    endtask

    initial begin
        logic [CB-1:0] c;
        reset        = 1'b0;
        strobe_in    = 1'b0;
        expect_resp  = 1'b0;
        cmd_in       = '0;
        ack_in       = 1'b0;
        pad_data_out = 1'b1;
        model_resp   = '0;

        // Reset held for three edges.
        tick(); tick(); tick();
        chk1("rst_oe", pad_output_input, 1'b1);
        chk1("rst_data", pad_data_in, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_enable", pad_enable, 1'b0);
        chkw("rst_response", response, '0);
        chk1("rst_valid", response_valid, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        reset = 1'b1;
        tick();
        chk1("enable_after_release", pad_enable, 1'b1);

        // Directed: no-response command, response after 5 wait cycles,
        // timeout, start bit on the expiry edge, start bit on the first edge.
        run_txn(48'h40_0000_0000_95, 1'b0, 0, '0, 2);
        run_txn(48'h40_0000_0000_95, 1'b1, 5, 48'h08_0000_01AA_13, 1);
        run_txn(48'h48_0000_01AA_87, 1'b1, TO + 1, '0, 1);
        run_txn(48'h77_1234_5678_9A, 1'b1, TO, 48'h3F_FFFF_FFFF_FF, 0);
        run_txn(48'h01_0203_0405_06, 1'b1, 1, 48'h2A_5555_AAAA_01, 0);

        // Reset pulsed during bit 20 of SEND.
        c = 48'hC3_A5F0_0F5A_3C;
        strobe_in   = 1'b1;
        cmd_in      = c;
        expect_resp = 1'b1;
        tick();
        strobe_in = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk1("pre_abort_bit20", pad_data_in, c[CB-1-20]);
        reset = 1'b0;
        tick();
        model_resp = '0;
        chk1("abort_oe", pad_output_input, 1'b1);
        chk1("abort_data", pad_data_in, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_enable", pad_enable, 1'b0);
        chkw("abort_response", response, model_resp);
        reset = 1'b1;
        tick();
        chk1("abort_enable_back", pad_enable, 1'b1);
        run_txn(c, 1'b1, 3, 48'h11_2233_4455_66, 1);

        // Randomized transactions.
        for (int t = 0; t < 20; t++) begin
            run_txn(CB'({$urandom(), $urandom()}), 1'($urandom()),
                    int'($urandom_range(1, TO + 4)),
                    RB'({$urandom(), $urandom()}), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
